// File: rtl/i2c_slave_pkg.sv
// Shared state encoding and bus constants for the i2c_slave register target.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } slv_t;

    localparam logic        ACK           = 1'b0;
    localparam logic        NACK          = 1'b1;
    localparam int unsigned RW_BIT        = 0;
    localparam logic [3:0]  BITS_PER_BYTE = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Register-side bus of the I2C target: pointer, write strobe/data, read data.
interface i2c_slave_if #(
    parameter int unsigned AW = 8
);
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic [7:0]    reg_rdata;

    modport slave  (output reg_addr, output reg_wdata, output reg_we, input  reg_rdata);
    modport master (input  reg_addr, input  reg_wdata, input  reg_we, output reg_rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// Per-line synchroniser with edge detect; I2C_SLAVE_GLITCH_FILTER_EN adds a
// 3-sample majority-free level filter (level accepted after 3 equal samples).
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic level_s;

    // Two-flop synchroniser and edge-history next values.
    always_comb begin
        meta_d = line_i;
        sync_d = meta_q;
        prev_d = level_s;
    end

    // Synchroniser and edge-history registers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    // Filter: the level only moves once three consecutive samples agree.
    always_comb begin
        hist_d = {hist_q[0], sync_q};
        if ({hist_q, sync_q} == 3'b111) begin
            filt_d = 1'b1;
        end else if ({hist_q, sync_q} == 3'b000) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
    end

    // Filter history and accepted level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign level_s = filt_q;
`else
    assign level_s = sync_q;
`endif

    assign level_o = level_s;
    assign rise_o  = level_s & ~prev_q;
    assign fall_o  = ~level_s & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing a pointer-addressed register port; no clock stretching.
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables the line glitch filter.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned AW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    i2c_slave_if.slave bus,
    output logic       busy,
    output slv_t       st
);
    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] rx_byte_s;

    slv_t          st_q, st_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [6:0]    tx_q, tx_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          reg_we_q, reg_we_d;
    logic          busy_q, busy_d;
    logic          sda_oe_q, sda_oe_d;

    i2c_line_sync u_scl_sync (
        .clk(clk), .rst(rst), .line_i(scl),
        .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );

    i2c_line_sync u_sda_sync (
        .clk(clk), .rst(rst), .line_i(sda),
        .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    assign rx_byte_s = {shift_q, sda_lvl_s};

    // Next-state and datapath: START/STOP override, then per-state bit handling.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        busy_d      = busy_q;
        sda_oe_d    = sda_oe_q;
        if (stop_s) begin
            st_d     = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_s) begin
            st_d     = ADDR;
            cnt_d    = BITS_PER_BYTE;
            sda_oe_d = 1'b0;
        end else begin
            case (st_q)
                IDLE, IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR, PTR, WDATA: begin
                    if (scl_rise_s) begin
                        shift_d = rx_byte_s[6:0];
                        cnt_d   = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            case (st_q)
                                ADDR: begin
                                    if (addr_match(rx_byte_s, DEV_ADDR)) begin
                                        st_d = ADDR_ACK;
                                        rw_d = rx_byte_s[RW_BIT];
                                    end else begin
                                        st_d   = IGNORE;
                                        busy_d = 1'b0;
                                    end
                                end
                                PTR: begin
                                    reg_addr_d = rx_byte_s[AW-1:0];
                                    st_d       = PTR_ACK;
                                end
                                WDATA: begin
                                    reg_wdata_d = rx_byte_s;
                                    reg_we_d    = 1'b1;
                                    st_d        = WDATA_ACK;
                                end
                                default: st_d = IDLE;
                            endcase
                        end else begin
                            st_d = st_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                // First SCL fall starts the ACK pulse, the second ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = (st_q == ADDR_ACK) ? 1'b1 : busy_q;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = BITS_PER_BYTE;
                            case (st_q)
                                ADDR_ACK: begin
                                    if (rw_q) begin
                                        st_d     = RDATA;
                                        tx_d     = bus.reg_rdata[6:0];
                                        sda_oe_d = ~bus.reg_rdata[7];
                                    end else begin
                                        st_d = PTR;
                                    end
                                end
                                PTR_ACK:   st_d = WDATA;
                                WDATA_ACK: begin
                                    st_d       = WDATA;
                                    reg_addr_d = reg_addr_q + {{(AW-1){1'b0}}, 1'b1};
                                end
                                default:   st_d = IDLE;
                            endcase
                        end
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                RDATA: begin
                    if (scl_rise_s) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (scl_fall_s) begin
                        if (cnt_q == 4'd0) begin
                            sda_oe_d = 1'b0;
                            st_d     = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end else begin
                        tx_d = tx_q;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_lvl_s == ACK) begin
                            reg_addr_d = reg_addr_q + {{(AW-1){1'b0}}, 1'b1};
                        end else begin
                            st_d   = IGNORE;
                            busy_d = 1'b0;
                        end
                    end else if (scl_fall_s) begin
                        st_d     = RDATA;
                        cnt_d    = BITS_PER_BYTE;
                        tx_d     = bus.reg_rdata[6:0];
                        sda_oe_d = ~bus.reg_rdata[7];
                    end else begin
                        st_d = st_q;
                    end
                end
                default: begin
                    st_d     = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 7'd0;
            rw_q        <= 1'b0;
            reg_addr_q  <= {AW{1'b0}};
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    // Reset releases the line combinationally so the bus is freed in the same clock.
    assign sda           = (sda_oe_q && !rst) ? 1'b0 : 1'bz;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign busy          = busy_q;
    assign st            = st_q;

endmodule
